bar_update_scheduler: RTL and testbench

- Sits directly upstream of the bar-graph visualizer and drives its row-value write port (tg_write_en/tg_addr/tg_input).
- Accepts asynchronous per-row value updates from the producer through a valid/ready handshake and holds them in a shadow buffer with dirty bits.
- Commits dirty rows into the visualizer RAM only during vertical blanking. The visualizer's write port pre-empts its read address, so a write during active video corrupts the displayed row.
- Saturates values to the drawable bar width.

---
 rtl/vis_pkg.sv | 10 +
 rtl/bar_saturate.sv | 15 +
 rtl/bar_update_scheduler.sv | 87 ++++++++
 tb/tb_bar_update_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/vis_pkg.sv
// Shared constants and types for the bar-graph visualizer and the blocks that feed it.
package vis_pkg;
  localparam int SCREEN_WIDTH  = 76;
  localparam int SCREEN_HEIGHT = 42;
  localparam int VBLANK_START  = 720;
  localparam int ROW_W         = $clog2(SCREEN_HEIGHT);

  typedef enum logic {IDLE, FLUSH} sched_state_t;
  typedef logic [31:0] bar_val_t;
endpackage

// File: rtl/bar_saturate.sv
// Clamps an unsigned bar value to the drawable width; purely combinational.
module bar_saturate
  import vis_pkg::*;
(
  input  bar_val_t value,
  output bar_val_t sat_value
);
  localparam bar_val_t LIMIT = bar_val_t'(SCREEN_WIDTH);

  function automatic bar_val_t sat_width(input bar_val_t v);
    return (v > LIMIT) ? LIMIT : v;
  endfunction

  assign sat_value = sat_width(value);
endmodule

// File: rtl/bar_update_scheduler.sv
// Buffers producer row updates and commits dirty rows to the visualizer RAM
// only during vertical blanking, one row slot per cycle.
module bar_update_scheduler
  import vis_pkg::*;
(
  input  logic             pixel_clk_in,
  input  logic             rst_in,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  input  logic             upd_valid_in,
  output logic             upd_ready_out,
  input  logic [ROW_W-1:0] upd_addr_in,
  input  logic [31:0]      upd_data_in,
  output logic             tg_write_en,
  output logic [ROW_W-1:0] tg_addr,
  output logic [31:0]      tg_input,
  output logic             addr_err_out,
  output logic             flush_done_out
);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SCREEN_HEIGHT - 1);

  sched_state_t            state, state_nxt;
  logic [ROW_W-1:0]        idx;
  bar_val_t                shadow [SCREEN_HEIGHT];
  logic [SCREEN_HEIGHT-1:0] dirty;
  bar_val_t                cur_val, sat_val;
  logic                    accept, addr_ok, trigger, last_row;

  assign upd_ready_out = (state == IDLE) && !rst_in;
  assign accept        = upd_valid_in && upd_ready_out;
  assign addr_ok       = (upd_addr_in <= LAST_ROW);
  assign trigger       = (vcount_in == 10'(VBLANK_START)) && (hcount_in == '0);
  assign last_row      = (idx == LAST_ROW);
  assign cur_val       = shadow[idx];

  bar_saturate u_sat (
    .value     (cur_val),
    .sat_value (sat_val)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger)  state_nxt = FLUSH;
      FLUSH:   if (last_row) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow data is never reset; only dirty bits qualify it.
  always_ff @(posedge pixel_clk_in) begin
    if (accept && addr_ok) shadow[upd_addr_in] <= upd_data_in;
  end

  // Flush slot k reads row idx; the write strobe for it appears in slot k+1.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      idx            <= '0;
      dirty          <= '0;
      tg_write_en    <= 1'b0;
      tg_addr        <= '0;
      tg_input       <= '0;
      addr_err_out   <= 1'b0;
      flush_done_out <= 1'b0;
    end else begin
      state          <= state_nxt;
      addr_err_out   <= accept && !addr_ok;
      tg_write_en    <= 1'b0;
      tg_addr        <= '0;
      tg_input       <= '0;
      flush_done_out <= 1'b0;
      if (state == FLUSH) begin
        idx            <= last_row ? '0 : idx + ROW_W'(1);
        flush_done_out <= last_row;
        dirty[idx]     <= 1'b0;
        if (dirty[idx]) begin
          tg_write_en <= 1'b1;
          tg_addr     <= idx;
          tg_input    <= sat_val;
        end
      end
      // Accepts only happen in IDLE, so this never collides with the clear above.
      if (accept && addr_ok) dirty[upd_addr_in] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bar_update_scheduler.sv
// Self-checking bench for bar_update_scheduler: table-driven updates plus
// hand-written blanking, stall and reset sequences, with a write scoreboard.
module tb_bar_update_scheduler;
  import vis_pkg::*;

  logic             clk = 1'b0;
  logic             rst, valid, ready, wen, aerr, fdone;
  logic [10:0]      hcount;
  logic [9:0]       vcount;
  logic [ROW_W-1:0] addr, taddr;
  logic [31:0]      data, tin;

  int errors = 0;
  int checks = 0;
  int stray  = 0;
  bit in_flush = 1'b0;

  typedef struct {
    int               slot;
    logic [ROW_W-1:0] addr;
    logic [31:0]      val;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [ROW_W-1:0] addr;
    logic [31:0]      data;
    logic [31:0]      exp;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  bar_update_scheduler dut (
    .pixel_clk_in   (clk),
    .rst_in         (rst),
    .hcount_in      (hcount),
    .vcount_in      (vcount),
    .upd_valid_in   (valid),
    .upd_ready_out  (ready),
    .upd_addr_in    (addr),
    .upd_data_in    (data),
    .tg_write_en    (wen),
    .tg_addr        (taddr),
    .tg_input       (tin),
    .addr_err_out   (aerr),
    .flush_done_out (fdone)
  );

  always @(negedge clk) if (wen === 1'b1 && !in_flush) stray++;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_wr(input int slot, input logic [ROW_W-1:0] a, input logic [31:0] v);
    wr_t e;
    e.slot = slot; e.addr = a; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic check_write(input int c);
    wr_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_write: slot %0d addr %0d val %0d, required no write", c - 1, taddr, tin);
    end else begin
      e = exp_q.pop_front();
      chk("write_slot", c - 1, e.slot);
      chk("write_addr", taddr, e.addr);
      chk("write_val", tin, e.val);
    end
  endtask

  task automatic send(input logic [ROW_W-1:0] a, input logic [31:0] d);
    int n = 0;
    valid = 1'b1; addr = a; data = d;
    @(negedge clk);
    while (!ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("send_timeout", n, 0);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  // Trigger a blanking flush and observe 44 cycles; swap changes the held data after the trigger.
  task automatic run_flush(input string tag, input bit swap);
    int lowcnt = 0;
    int donecnt = 0;
    int done_c = -1;
    in_flush = 1'b1;
    vcount = 10'(VBLANK_START); hcount = '0;
    @(posedge clk); #1;
    if (swap) data = 32'd11;
    hcount = 11'd1;
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      if (!ready) lowcnt++;
      if (wen) check_write(c);
      if (fdone) begin donecnt++; done_c = c; end
      @(posedge clk); #1;
      if (c == 43) valid = 1'b0;
      hcount = (c == 4) ? 11'd0 : hcount + 11'd1;
    end
    chk({tag, "_ready_low_cycles"}, lowcnt, 42);
    chk({tag, "_done_count"}, donecnt, 1);
    chk({tag, "_done_cycle"}, done_c, 43);
    chk({tag, "_missing_writes"}, exp_q.size(), 0);
    exp_q.delete();
    vcount = 10'd100; hcount = '0;
    in_flush = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0] = '{6'd0,  32'd0,          32'd0};
    tbl[1] = '{6'd1,  32'd75,         32'd75};
    tbl[2] = '{6'd2,  32'd76,         32'd76};
    tbl[3] = '{6'd3,  32'd77,         32'd76};
    tbl[4] = '{6'd4,  32'hFFFF_FFFF,  32'd76};
    tbl[5] = '{6'd10, 32'h8000_0000,  32'd76};
    tbl[6] = '{6'd20, 32'd1,          32'd1};
    tbl[7] = '{6'd41, 32'd1000,       32'd76};

    rst = 1'b1; valid = 1'b0; addr = '0; data = '0;
    vcount = 10'd100; hcount = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_ready", ready, 0);
    chk("reset_wen", wen, 0);
    chk("reset_addr", taddr, 0);
    chk("reset_input", tin, 0);
    chk("reset_addr_err", aerr, 0);
    chk("reset_done", fdone, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", ready, 1);
    @(posedge clk); #1;

    run_flush("idle", 1'b0);

    send(6'd5, 32'd10);
    send(6'd41, 32'd3);
    push_wr(6, 6'd5, 32'd10);
    push_wr(42, 6'd41, 32'd3);
    run_flush("two_rows", 1'b0);

    send(6'd7, 32'd20);
    send(6'd7, 32'd200);
    push_wr(8, 6'd7, 32'd76);
    run_flush("last_wins", 1'b0);
    run_flush("clean_frame", 1'b0);

    send(6'd42, 32'd5);
    @(negedge clk);
    chk("addr_err_pulse", aerr, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("addr_err_single", aerr, 0);
    @(posedge clk); #1;
    run_flush("bad_addr", 1'b0);

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].addr, tbl[i].data);
      push_wr(int'(tbl[i].addr) + 1, tbl[i].addr, tbl[i].exp);
    end
    run_flush("table", 1'b0);

    valid = 1'b1; addr = 6'd3; data = 32'd9;
    push_wr(4, 6'd3, 32'd9);
    run_flush("stall_first", 1'b1);
    push_wr(4, 6'd3, 32'd11);
    run_flush("stall_second", 1'b0);

    for (int r = 0; r < SCREEN_HEIGHT; r++) send(ROW_W'(r), 32'(r + 1));
    for (int s = 1; s <= 9; s++) push_wr(s, ROW_W'(s - 1), 32'(s));
    in_flush = 1'b1;
    vcount = 10'(VBLANK_START); hcount = '0;
    @(posedge clk); #1;
    hcount = 11'd1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 10) chk("abort_ready_in_reset", ready, 0);
      if (c == 11) begin
        chk("abort_wen", wen, 0);
        chk("abort_ready_after", ready, 1);
      end
      if (wen) check_write(c);
      @(posedge clk); #1;
      hcount = hcount + 11'd1;
      if (c == 9) rst = 1'b1;
      if (c == 10) rst = 1'b0;
    end
    chk("abort_missing_writes", exp_q.size(), 0);
    exp_q.delete();
    vcount = 10'd100; hcount = '0;
    in_flush = 1'b0;
    @(posedge clk); #1;
    run_flush("after_abort", 1'b0);

    chk("writes_outside_blanking", stray, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
